// File: rtl/burst_scheduler.sv
// burst_scheduler: sequences the TX RF chain around each burst.
// Powers up the PA, waits for warm-up, fires tx_burst once it is armed,
// watches the IQ-valid window, ramps down and enforces an inter-burst gap.
// Requests come from a synchronized trigger pin or a periodic generator.
module burst_scheduler #(
    parameter int WARMUP_CYCLES   = 1024,
    parameter int COOLDOWN_CYCLES = 256,
    parameter int MIN_GAP_CYCLES  = 4096,
    parameter int TIMEOUT_CYCLES  = 65536,
    parameter int CNT_W           = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic        periodic_en,
    input  logic [23:0] period,
    input  logic        modulator_armed,
    input  logic        modulator_iq_valid,
    output logic        fire_burst,
    output logic        pa_enable,
    output logic        busy,
    output logic [15:0] burst_count,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_WAIT_ARMED,
        S_FIRE,
        S_ACTIVE,
        S_COOLDOWN,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] WARMUP_LAST   = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'(MIN_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic [23:0]       per_cnt_q, per_cnt_d;
    logic              pending_q, pending_d;
    logic              iq_prev_q;
    logic              seen_rise_q, seen_rise_d;
    logic              fire_q, pa_q, busy_q;
    logic [15:0]       burst_count_q, burst_count_d;
    logic              fault_q, fault_d;

    logic              trig_edge;
    logic              per_req;
    logic              iq_rise;
    logic              iq_fall;

    assign fire_burst  = fire_q;
    assign pa_enable   = pa_q;
    assign busy        = busy_q;
    assign burst_count = burst_count_q;
    assign fault       = fault_q;

    // Request sources: synchronized trigger edge, periodic counter wrap, single-deep latch.
    always_comb begin
        trig_edge = sync2_q & ~sync3_q;
        per_req   = 1'b0;
        per_cnt_d = 24'd0;
        if (periodic_en && (period != 24'd0)) begin
            if (per_cnt_q == (period - 24'd1)) begin
                per_req   = 1'b1;
                per_cnt_d = 24'd0;
            end else begin
                per_cnt_d = per_cnt_q + 24'd1;
            end
        end
        pending_d = pending_q;
        if ((state_q == S_IDLE) && pending_q) begin
            pending_d = 1'b0;
        end
        if (trig_edge || per_req) begin
            pending_d = 1'b1;
        end
    end

    // Burst sequencing FSM; the shared delay counter restarts on every state change.
    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        burst_count_d = burst_count_q;
        seen_rise_d   = 1'b0;
        iq_rise       = modulator_iq_valid & ~iq_prev_q;
        iq_fall       = ~modulator_iq_valid & iq_prev_q & seen_rise_q;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (cnt_q == WARMUP_LAST) state_d = S_WAIT_ARMED;
            end
            S_WAIT_ARMED: begin
                if (modulator_armed) begin
                    state_d = S_FIRE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_COOLDOWN;
                end
            end
            S_FIRE: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                seen_rise_d = seen_rise_q | iq_rise;
                if (iq_fall) begin
                    burst_count_d = burst_count_q + 16'd1;
                    state_d       = S_COOLDOWN;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cnt_q == COOLDOWN_LAST) state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // All state and registered outputs; outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            per_cnt_q     <= 24'd0;
            pending_q     <= 1'b0;
            iq_prev_q     <= 1'b0;
            seen_rise_q   <= 1'b0;
            fire_q        <= 1'b0;
            pa_q          <= 1'b0;
            busy_q        <= 1'b0;
            burst_count_q <= 16'd0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= trigger;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            per_cnt_q     <= per_cnt_d;
            pending_q     <= pending_d;
            iq_prev_q     <= modulator_iq_valid;
            seen_rise_q   <= seen_rise_d;
            fire_q        <= (state_d == S_FIRE);
            pa_q          <= (state_d == S_WARMUP) || (state_d == S_WAIT_ARMED) ||
                             (state_d == S_FIRE) || (state_d == S_ACTIVE) ||
                             (state_d == S_COOLDOWN);
            busy_q        <= (state_d != S_IDLE);
            burst_count_q <= burst_count_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: doc/burst_scheduler.md
Name: burst_scheduler

Overview:
- Sequences the TX path around each burst: powers up the RF chain, waits for warm-up, issues a single-cycle fire pulse to the burst controller once it reports armed, then watches the IQ-valid window, ramps down, and enforces a minimum inter-burst gap.
- Sits between the external trigger pin and the fire_burst/is_armed/iq_valid interface of tx_burst.
- Also generates periodic bursts and flags hung bursts.

Parameters:
- WARMUP_CYCLES, 1024: cycles of pa_enable before a burst may be fired.
- COOLDOWN_CYCLES, 256: cycles pa_enable stays high after the burst ends.
- MIN_GAP_CYCLES, 4096: cycles in GAP before a new request is serviced.
- TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_ARMED, or in ACTIVE, before fault.
- CNT_W, 17: width of the internal delay counter; must hold the largest cycle parameter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trigger  in  1  asynchronous burst request pin
- periodic_en  in  1  enable the internal periodic request generator
- period  in  24  periodic interval in cycles; 0 disables periodic requests
- modulator_armed  in  1  tx_burst is_armed
- modulator_iq_valid  in  1  tx_burst iq_valid
- fire_burst  out  1  one-cycle fire pulse to tx_burst
- pa_enable  out  1  RF chain power enable
- busy  out  1  high in every state except IDLE
- burst_count  out  16  count of completed bursts
- fault  out  1  sticky timeout flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port `clock`, reset port `reset`.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - pending, period counter and synchronizer flops cleared.
  - Reset asserted mid-burst drops pa_enable on the next edge; no cooldown is run.
- trigger input:
  - Passes through a 2-flop synchronizer, then rising-edge detect, giving trig_edge.
  - Synchronizer-to-request latency is 3 cycles from pin rise.
- Periodic generator:
  - While periodic_en=1 and period!=0, a counter counts 0..period-1.
  - At period-1 it raises per_req for one cycle and wraps to 0.
  - Clearing periodic_en holds the counter at 0.
- Request latch:
  - pending sets on trig_edge or per_req, and is single-deep.
  - Additional requests while pending=1 are discarded.
  - pending clears on the IDLE->WARMUP transition.
  - A new request in that same cycle re-sets pending.
- FSM (registered, one transition per cycle at most):
  - IDLE: pending=1 -> WARMUP.
  - WARMUP:
    - pa_enable=1; counter counts WARMUP_CYCLES cycles.
    - Then -> WAIT_ARMED.
  - WAIT_ARMED:
    - modulator_armed=1 -> FIRE.
    - TIMEOUT_CYCLES elapsed without it -> fault=1, COOLDOWN.
  - FIRE: exactly one cycle with fire_burst=1 -> ACTIVE.
  - ACTIVE: the timeout counter spans the whole state.
    - Waits for a rising then a falling edge of modulator_iq_valid.
    - On the fall: burst_count increments (wraps 0xFFFF -> 0) -> COOLDOWN.
    - Timeout with no rise, or no fall after rise -> fault=1, COOLDOWN; no count increment.
  - COOLDOWN: pa_enable=1 for COOLDOWN_CYCLES cycles -> GAP.
  - GAP: pa_enable=0 for MIN_GAP_CYCLES cycles -> IDLE. Requests arriving here latch into pending.
- pa_enable:
  - Registered.
  - High in the cycle the state register holds WARMUP, WAIT_ARMED, FIRE, ACTIVE or COOLDOWN.
  - Low otherwise.
- Timing: trigger pin rise to fire_burst with armed already high = 3 + 1 + WARMUP_CYCLES + 1 cycles.
- Counter:
  - A single delay counter is shared by all timed states.
  - It is cleared on every state entry.
  - The state is exited when counter == param-1.
- fault:
  - Sticky until reset.
  - Does not block further bursts.

Test Plan:
- Single trigger, WARMUP=16, armed tied 1, iq_valid pulses high 40 cycles after fire -> fire_burst exactly one pulse at cycle 21 after pin rise; pa_enable high through burst plus 256 cooldown cycles; burst_count=1; fault=0.
- Three triggers 5 cycles apart while busy -> one burst runs, one pending burst follows after GAP; burst_count=2.
- armed held 0, TIMEOUT=100 -> fault=1 after 100 WAIT_ARMED cycles; no fire pulse; COOLDOWN and GAP still run; returns to IDLE.
- iq_valid never falls after rising, TIMEOUT=100 -> fault=1; burst_count unchanged.
- periodic_en=1, period=10000, WARMUP=16, COOLDOWN=16, GAP=64, burst length well under the period -> one fire pulse every 10000 cycles; period=0 -> no bursts.
- Reset asserted in ACTIVE -> next edge: pa_enable=0, busy=0, burst_count=0, fault=0; a trigger after reset release fires normally.
